// File: rtl/riscv_alu_pkg.sv
// ALU opcode encodings shared by the ID/EX stage and the ALU, plus the
// control-bit bundle carried from decode into EX.
package riscv_alu_pkg;

    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_OR   = 5'b00001;
    localparam logic [4:0] ALU_XOR  = 5'b00010;
    localparam logic [4:0] ALU_ADD  = 5'b00011;
    localparam logic [4:0] ALU_SUB  = 5'b00100;
    localparam logic [4:0] ALU_SLT  = 5'b00101;
    localparam logic [4:0] ALU_SLTU = 5'b00110;
    localparam logic [4:0] ALU_SLL  = 5'b00111;
    localparam logic [4:0] ALU_SRL  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01001;
    localparam logic [4:0] ALU_BLTU = 5'b01010;
    localparam logic [4:0] ALU_BGEU = 5'b01011;

    localparam logic [4:0] ALU_OP_MAX = ALU_BGEU;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
    } ctrl_t;

    function automatic logic is_shift_op(input logic [4:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// One-operand forwarding select: EX/MEM beats MEM/WB beats the register copy.
// x0 is never forwarded since its architectural value is always zero.
module fwd_mux #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic [RADDR_W-1:0] rs_addr_i,
    input  logic [XLEN-1:0]    rs_data_i,
    input  logic [RADDR_W-1:0] exmem_rd_i,
    input  logic               exmem_reg_write_i,
    input  logic [XLEN-1:0]    exmem_result_i,
    input  logic [RADDR_W-1:0] memwb_rd_i,
    input  logic               memwb_reg_write_i,
    input  logic [XLEN-1:0]    memwb_result_i,
    output logic [XLEN-1:0]    data_o
);

    logic hit_exmem;
    logic hit_memwb;

    assign hit_exmem = exmem_reg_write_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_addr_i);
    assign hit_memwb = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_addr_i);

    always_comb begin
        data_o = rs_data_i;
        if (hit_exmem)
            data_o = exmem_result_i;
        else if (hit_memwb)
            data_o = memwb_result_i;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: forwarding, operand select, shift
// masking, flush/load-use bubbles. ID_EX_PERF_CNT_EN adds bubble/stall counters.
module id_ex_stage
    import riscv_alu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [RADDR_W-1:0] id_rs1_addr,
    input  logic [RADDR_W-1:0] id_rs2_addr,
    input  logic [RADDR_W-1:0] id_rd_addr,
    input  logic [4:0]         id_alu_op,
    input  logic               id_src_a,
    input  logic               id_src_b,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic               id_branch,
    input  logic               stall,
    input  logic               flush,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic               exmem_reg_write,
    input  logic               memwb_reg_write,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic [XLEN-1:0]    memwb_result,
    output logic               load_use,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_A,
    output logic [XLEN-1:0]    ex_B,
    output logic [4:0]         ex_alu_op,
    output logic [XLEN-1:0]    ex_store_data,
    output logic [XLEN-1:0]    ex_pc,
    output logic [RADDR_W-1:0] ex_rd_addr,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
`ifdef ID_EX_PERF_CNT_EN
    output logic [31:0]        perf_bubbles,
    output logic [31:0]        perf_stalls,
`endif
    output logic               ex_branch
);

    logic               valid_q,    valid_d;
    logic [XLEN-1:0]    pc_q,       pc_d;
    logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]    imm_q,      imm_d;
    logic [RADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [RADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [RADDR_W-1:0] rd_q,       rd_d;
    logic [4:0]         alu_op_q,   alu_op_d;
    logic               src_a_q,    src_a_d;
    logic               src_b_q,    src_b_d;
    ctrl_t              ctrl_q,     ctrl_d;

    logic [XLEN-1:0]    rs1_fwd;
    logic [XLEN-1:0]    rs2_fwd;
    logic               kill;

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs1 (
        .rs_addr_i         (rs1_addr_q),
        .rs_data_i         (rs1_data_q),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_result_i    (exmem_result),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_result_i    (memwb_result),
        .data_o            (rs1_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .RADDR_W(RADDR_W)) u_fwd_rs2 (
        .rs_addr_i         (rs2_addr_q),
        .rs_data_i         (rs2_data_q),
        .exmem_rd_i        (exmem_rd),
        .exmem_reg_write_i (exmem_reg_write),
        .exmem_result_i    (exmem_result),
        .memwb_rd_i        (memwb_rd),
        .memwb_reg_write_i (memwb_reg_write),
        .memwb_result_i    (memwb_result),
        .data_o            (rs2_fwd)
    );

    assign load_use = id_valid && valid_q && ctrl_q.mem_read && (rd_q != '0) &&
                      ((rd_q == id_rs1_addr) || (rd_q == id_rs2_addr));

    // Flush outranks stall, stall outranks load-use; both kill paths load a bubble.
    assign kill = flush || (!stall && load_use);

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_d       = rd_q;
        alu_op_d   = alu_op_q;
        src_a_d    = src_a_q;
        src_b_d    = src_b_q;
        ctrl_d     = ctrl_q;
        if (kill) begin
            valid_d    = 1'b0;
            pc_d       = '0;
            rs1_data_d = '0;
            rs2_data_d = '0;
            imm_d      = '0;
            rs1_addr_d = '0;
            rs2_addr_d = '0;
            rd_d       = '0;
            alu_op_d   = ALU_AND;
            src_a_d    = 1'b0;
            src_b_d    = 1'b0;
            ctrl_d     = '0;
        end else if (stall) begin
            // Capture whatever is being forwarded now so a producer that
            // retires during the stall is not lost.
            rs1_data_d = rs1_fwd;
            rs2_data_d = rs2_fwd;
        end else begin
            valid_d    = id_valid;
            pc_d       = id_pc;
            rs1_data_d = id_rs1_data;
            rs2_data_d = id_rs2_data;
            imm_d      = id_imm;
            rs1_addr_d = id_rs1_addr;
            rs2_addr_d = id_rs2_addr;
            rd_d       = id_rd_addr;
            alu_op_d   = (id_alu_op > ALU_OP_MAX) ? ALU_AND : id_alu_op;
            src_a_d    = id_src_a;
            src_b_d    = id_src_b;
            ctrl_d     = id_valid ? ctrl_t'{id_reg_write, id_mem_read, id_mem_write, id_branch}
                                  : ctrl_t'('0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_q       <= '0;
            alu_op_q   <= ALU_AND;
            src_a_q    <= 1'b0;
            src_b_q    <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_q       <= rd_d;
            alu_op_q   <= alu_op_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            ctrl_q     <= ctrl_d;
        end
    end

    always_comb begin
        ex_B = src_b_q ? imm_q : rs2_fwd;
        if (is_shift_op(alu_op_q))
            ex_B[XLEN-1:5] = '0;
    end

    assign ex_A          = src_a_q ? pc_q : rs1_fwd;
    assign ex_store_data = rs2_fwd;
    assign ex_valid      = valid_q;
    assign ex_alu_op     = alu_op_q;
    assign ex_pc         = pc_q;
    assign ex_rd_addr    = rd_q;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_branch     = ctrl_q.branch;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubbles_q, perf_bubbles_d;
    logic [31:0] perf_stalls_q,  perf_stalls_d;

    assign perf_bubbles_d = kill  ? perf_bubbles_q + 32'd1 : perf_bubbles_q;
    assign perf_stalls_d  = stall ? perf_stalls_q  + 32'd1 : perf_stalls_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_bubbles_q <= '0;
            perf_stalls_q  <= '0;
        end else begin
            perf_bubbles_q <= perf_bubbles_d;
            perf_stalls_q  <= perf_stalls_d;
        end
    end

    assign perf_bubbles = perf_bubbles_q;
    assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: stimulus pushes expected outputs,
// a negedge monitor pops and compares. Checks perf counters if ID_EX_PERF_CNT_EN.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_alu_op;
    logic        id_src_a, id_src_b, id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic        stall, flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic        load_use, ex_valid;
    logic [31:0] ex_A, ex_B, ex_store_data, ex_pc;
    logic [4:0]  ex_alu_op, ex_rd_addr;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubbles, perf_stalls;
`endif

    id_ex_stage #(.XLEN(32), .RADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_op(id_alu_op), .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_branch(id_branch),
        .stall(stall), .flush(flush),
        .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
        .exmem_result(exmem_result), .memwb_result(memwb_result),
        .load_use(load_use), .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B),
        .ex_alu_op(ex_alu_op), .ex_store_data(ex_store_data), .ex_pc(ex_pc),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
`ifdef ID_EX_PERF_CNT_EN
        .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls),
`endif
        .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        v;
        logic [4:0]  op;
        logic [31:0] a, b, sd;
        logic        lu, rw, mr;
        logic [4:0]  rd;
        bit          cp;
        logic [31:0] pb, ps;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void cmp(input string nm, input string f,
                                input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, f, act, want);
        end
    endfunction

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.nm, "ex_valid",      {31'd0, ex_valid},     {31'd0, e.v});
            cmp(e.nm, "ex_alu_op",     {27'd0, ex_alu_op},    {27'd0, e.op});
            cmp(e.nm, "ex_A",          ex_A,                  e.a);
            cmp(e.nm, "ex_B",          ex_B,                  e.b);
            cmp(e.nm, "ex_store_data", ex_store_data,         e.sd);
            cmp(e.nm, "load_use",      {31'd0, load_use},     {31'd0, e.lu});
            cmp(e.nm, "ex_reg_write",  {31'd0, ex_reg_write}, {31'd0, e.rw});
            cmp(e.nm, "ex_mem_read",   {31'd0, ex_mem_read},  {31'd0, e.mr});
            cmp(e.nm, "ex_rd_addr",    {27'd0, ex_rd_addr},   {27'd0, e.rd});
`ifdef ID_EX_PERF_CNT_EN
            if (e.cp) begin
                cmp(e.nm, "perf_bubbles", perf_bubbles, e.pb);
                cmp(e.nm, "perf_stalls",  perf_stalls,  e.ps);
            end
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic v, input logic [4:0] op,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd,
                              input logic lu, input logic rw, input logic mr, input logic [4:0] rd,
                              input bit cp = 1'b0, input logic [31:0] pb = 32'd0,
                              input logic [31:0] ps = 32'd0);
        exp_t e;
        e.nm = nm; e.v = v; e.op = op; e.a = a; e.b = b; e.sd = sd;
        e.lu = lu; e.rw = rw; e.mr = mr; e.rd = rd; e.cp = cp; e.pb = pb; e.ps = ps;
        exp_q.push_back(e);
    endtask

    task automatic set_id(input logic v, input logic [4:0] op, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm, input logic [31:0] pc,
                          input logic sa, input logic sb, input logic rw, input logic mr);
        id_valid = v; id_alu_op = op; id_rs1_addr = rs1; id_rs2_addr = rs2; id_rd_addr = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_pc = pc;
        id_src_a = sa; id_src_b = sb; id_reg_write = rw; id_mem_read = mr;
        id_mem_write = 1'b0; id_branch = 1'b0;
    endtask

    task automatic set_fwd(input logic [4:0] xrd, input logic xrw, input logic [31:0] xres,
                           input logic [4:0] wrd, input logic wrw, input logic [31:0] wres);
        exmem_rd = xrd; exmem_reg_write = xrw; exmem_result = xres;
        memwb_rd = wrd; memwb_reg_write = wrw; memwb_result = wres;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_id(0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_fwd(5'd0, 0, 0, 5'd0, 0, 0);

        tick(); rst_n = 1'b1;
        expect_out("reset", 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 1'b1, 32'd0, 32'd0);

        // ADD x1 = x5 + x6, reissued each cycle while forwarding varies
        tick(); set_id(1, 5'd3, 5'd5, 5'd6, 5'd1, 32'h55, 32'h66, 0, 32'h1000, 0, 0, 1, 0);
        expect_out("idle_after_reset", 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0);
        tick(); set_fwd(5'd5, 1, 32'h11, 5'd5, 1, 32'h22);
        expect_out("fwd_exmem", 1, 5'd3, 32'h11, 32'h66, 32'h66, 0, 1, 0, 5'd1);
        tick(); set_fwd(5'd5, 0, 32'h11, 5'd5, 1, 32'h22);
        expect_out("fwd_memwb", 1, 5'd3, 32'h22, 32'h66, 32'h66, 0, 1, 0, 5'd1);
        tick(); set_fwd(5'd0, 1, 32'h11, 5'd0, 1, 32'h22);
        expect_out("fwd_x0", 1, 5'd3, 32'h55, 32'h66, 32'h66, 0, 1, 0, 5'd1);
        // LW x7, 8(x2) enters ID; ADD x1 sees rs2 forwarded from EX/MEM
        tick(); set_fwd(5'd6, 1, 32'h77, 5'd0, 0, 0);
        set_id(1, 5'd3, 5'd2, 5'd0, 5'd7, 32'h100, 0, 32'h8, 32'h1004, 0, 1, 1, 1);
        expect_out("fwd_rs2", 1, 5'd3, 32'h55, 32'h77, 32'h77, 0, 1, 0, 5'd1);
        // ADD x8 = x3 + x7 behind the load
        tick(); set_fwd(5'd0, 0, 0, 5'd0, 0, 0);
        set_id(1, 5'd3, 5'd3, 5'd7, 5'd8, 32'h30, 32'hBAD, 0, 32'h1008, 0, 0, 1, 0);
        expect_out("load_use_hit", 1, 5'd3, 32'h100, 32'h8, 32'h0, 1, 1, 1, 5'd7);
        tick(); set_fwd(5'd7, 1, 32'h108, 5'd0, 0, 0);
        expect_out("load_use_bubble", 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0);
        // ADD x9 = x3 + x4 enters ID while ADD x8 gets x7 from MEM/WB
        tick(); set_fwd(5'd0, 0, 0, 5'd7, 1, 32'hCAFE);
        set_id(1, 5'd3, 5'd3, 5'd4, 5'd9, 32'h33, 32'h44, 0, 32'h100C, 0, 0, 1, 0);
        expect_out("load_use_fwd", 1, 5'd3, 32'h30, 32'hCAFE, 32'hCAFE, 0, 1, 0, 5'd8);
        // Three-cycle stall; x3 = 0xDEAD passes by on MEM/WB in the first one
        tick(); stall = 1'b1; set_fwd(5'd0, 0, 0, 5'd3, 1, 32'hDEAD);
        set_id(0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("stall_fwd", 1, 5'd3, 32'hDEAD, 32'h44, 32'h44, 0, 1, 0, 5'd9);
        tick(); set_fwd(5'd0, 0, 0, 5'd0, 0, 0);
        expect_out("stall_hold1", 1, 5'd3, 32'hDEAD, 32'h44, 32'h44, 0, 1, 0, 5'd9);
        tick();
        expect_out("stall_hold2", 1, 5'd3, 32'hDEAD, 32'h44, 32'h44, 0, 1, 0, 5'd9);
        // SLL x11 = x1 << 0x123 enters ID
        tick(); stall = 1'b0;
        set_id(1, 5'd7, 5'd1, 5'd0, 5'd11, 32'h1, 0, 32'h0000_0123, 32'h1010, 0, 1, 1, 0);
        expect_out("stall_refresh", 1, 5'd3, 32'hDEAD, 32'h44, 32'h44, 0, 1, 0, 5'd9);
        tick(); set_id(1, 5'h1F, 5'd0, 5'd0, 5'd12, 32'h5, 32'h7, 0, 32'h1014, 0, 0, 1, 0);
        expect_out("shift_mask", 1, 5'd7, 32'h1, 32'h3, 32'h0, 0, 1, 0, 5'd11);
        // Flush and stall together on the next edge
        tick(); flush = 1'b1; stall = 1'b1;
        set_id(1, 5'd3, 5'd1, 5'd0, 5'd13, 32'h1, 0, 0, 32'h1018, 0, 0, 1, 0);
        expect_out("bad_opcode", 1, 5'd0, 32'h5, 32'h7, 32'h7, 0, 1, 0, 5'd12, 1'b1, 32'd1, 32'd3);
        tick(); flush = 1'b0; stall = 1'b0;
        set_id(1, 5'd3, 5'd0, 5'd0, 5'd14, 32'h9, 0, 0, 32'h101C, 0, 0, 1, 0);
        expect_out("flush_stall", 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 1'b1, 32'd2, 32'd4);
        tick();
        expect_out("pre_reset", 1, 5'd3, 32'h9, 0, 0, 0, 1, 0, 5'd14);
        tick(); rst_n = 1'b0;
        expect_out("async_reset", 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0, 1'b1, 32'd0, 32'd0);
        tick(); rst_n = 1'b1;
        set_id(0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("post_reset", 0, 5'd0, 0, 0, 0, 0, 0, 0, 5'd0);

        tick(); tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0 entries left", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU.
- Registers the decoded instruction and resolves operand forwarding from EX/MEM and MEM/WB.
- Selects the A and B operands, masks shift amounts, inserts bubbles on flush and load-use, and produces the 5-bit ALU opcode consumed by the ALU.
- The ALU treats out-of-range opcodes as X; this stage never issues them.

Parameters:
- XLEN, 32, datapath width.
- RADDR_W, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  instruction PC
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data
- id_imm  in  XLEN  sign-extended immediate
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  RADDR_W  register indices
- id_alu_op  in  5  ALU opcode: 00000 AND … 01011 BGEU
- id_src_a  in  1  A operand select: 0 = rs1, 1 = PC
- id_src_b  in  1  B operand select: 0 = rs2, 1 = imm
- id_reg_write, id_mem_read, id_mem_write, id_branch  in  1  control bits
- stall  in  1  hold the stage (downstream back-pressure)
- flush  in  1  kill the instruction entering the stage (branch taken)
- exmem_rd, memwb_rd  in  RADDR_W  destinations of the older instructions
- exmem_reg_write, memwb_reg_write  in  1  write enables of the older instructions
- exmem_result, memwb_result  in  XLEN  forwarding data
- load_use  out  1  combinational load-use hazard; IF/ID must hold while high
- ex_valid  out  1  registered valid
- ex_A, ex_B  out  XLEN  ALU operands
- ex_alu_op  out  5  ALU opcode
- ex_store_data  out  XLEN  forwarded rs2 value for stores
- ex_pc  out  XLEN  registered PC
- ex_rd_addr  out  RADDR_W  registered destination
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch  out  1  registered control bits (forced to 0 when invalid)

Behaviour:
- **Reset (rst_n low, asynchronous):** all registers clear to 0, which is a bubble. ex_alu_op = 00000 (AND) and operands = 0, so the ALU yields res = 0, zero = 1.
- **Latency:** 1 cycle from ID inputs to the ex_* registers. ex_A, ex_B and ex_store_data are combinational from the registers plus the forwarding inputs.
- **Register update priority (highest first), evaluated at the clock edge:**
  1. flush → bubble: valid and all control bits = 0, alu_op = 00000, data registers = 0, rd = 0.
  2. stall → hold all fields. The rs1/rs2 data registers instead load their currently forwarded values (operand refresh), so a producer retiring during the stall is not lost.
  3. load_use → bubble.
  4. Otherwise → load the ID inputs. If id_valid = 0, all control bits are forced to 0.
- **load_use** = id_valid & ex_valid & ex_mem_read & ex_rd_addr != 0 & (ex_rd_addr == id_rs1_addr | ex_rd_addr == id_rs2_addr).
- **Forwarding, per rs operand:**
  - EX/MEM wins when exmem_reg_write & exmem_rd != 0 & exmem_rd == rs.
  - Otherwise MEM/WB wins under the same conditions.
  - Otherwise the registered data is used.
  - x0 is never forwarded.
- **ex_A** = PC if src_a, else forwarded rs1.
- **ex_B** = imm if src_b, else forwarded rs2.
- **Shift masking:** for alu_op 00111/01000/01001 (SLL/SRL/SRA), ex_B[XLEN-1:5] = 0. A shift amount never exceeds 31.
- **ex_store_data** = forwarded rs2, independent of src_b.
- **Opcode validation:** an id_alu_op above 01011 is replaced by 00000 when loaded.
- **Simultaneous flush and stall:** flush wins.
- **Simultaneous stall and load_use:** the stage holds; load_use is still driven so that IF/ID holds.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- **Defined:**
  - Adds outputs perf_bubbles[31:0] and perf_stalls[31:0].
  - perf_bubbles increments on each edge that loads a bubble from flush or load_use.
  - perf_stalls increments on each edge with stall = 1.
  - Both counters wrap 0xFFFFFFFF → 0 and reset to 0.
- **Undefined:** the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package riscv_alu_pkg holds:
  - ALU_AND … ALU_BGEU localparams (5-bit, 00000–01011);
  - ALU_OP_MAX = 01011;
  - the shift-op test function.
- Sub-module fwd_mux: 3-way forwarding select for one operand (rs addr, reg data, EX/MEM and MEM/WB inputs), instanced twice.

Test Plan:
- **Reset bubble:** rst_n low mid-stream with ex_valid = 1 → immediately ex_valid = 0, ex_alu_op = 00000, ex_A = ex_B = 0.
- **Forward priority:** ADD with rs1 = x5; exmem_rd = 5 (0x11), memwb_rd = 5 (0x22) → ex_A = 0x11. With exmem_reg_write = 0 → ex_A = 0x22. With rd = 0 → ex_A = the register value.
- **Load-use:** LW x7 in EX, ID ADD using rs2 = x7 → load_use = 1, next edge is a bubble, the following edge carries the ADD with x7 forwarded from memwb.
- **Stall refresh:** stall for 3 cycles while memwb carries rs1 = 0xDEAD that then leaves → after the stall, ex_A = 0xDEAD.
- **Shift mask:** SLL with imm = 0x0000_0123 → ex_B = 0x0000_0003. Invalid opcode 11111 → ex_alu_op = 00000.
- **Flush vs stall:** flush = stall = 1 → next edge ex_valid = 0, ex_reg_write = 0. With ID_EX_PERF_CNT_EN defined, perf_bubbles increments by 1 and perf_stalls by 1.
